// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/SHADOW
// FSM that accepts one EX-stage branch redirect, then ignores the flushed slot behind it.
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_en,
    input  logic        addermuxselect,
    input  logic [63:0] branch_target,
    input  logic [31:0] imem_instr,
    output logic [63:0] pc_out,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        flush,
    output logic        misalign_err,
    output logic [31:0] taken_count,
    output logic        o_state_dbg
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_redirect;
    logic [63:0] r_pc;
    logic [63:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_misalign_err;
    logic [31:0] r_taken_count;
    logic [31:0] w_taken_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:    if (w_redirect) w_state_next = ST_SHADOW;
            ST_SHADOW: w_state_next = ST_RUN;
            default:   w_state_next = ST_RUN;
        endcase
    end

    // Redirect is gated by reset so flush stays low while reset is asserted.
    always_comb begin
        w_redirect = 1'b0;
        if (reset && (r_state == ST_RUN) && branch_en && addermuxselect) begin
            w_redirect = 1'b1;
        end
    end

    always_comb begin
        w_taken_next = r_taken_count;
        if (w_redirect && (r_taken_count != 32'hFFFF_FFFF)) begin
            w_taken_next = r_taken_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc           <= RESET_PC;
            r_if_id_pc     <= 64'd0;
            r_if_id_instr  <= NOP_INSTR;
            r_if_id_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_taken_count  <= 32'd0;
        end else begin
            r_taken_count <= w_taken_next;
            if (w_redirect) begin
                r_pc          <= {branch_target[63:2], 2'b00};
                r_if_id_pc    <= 64'd0;
                r_if_id_instr <= NOP_INSTR;
                r_if_id_valid <= 1'b0;
                if (branch_target[1:0] != 2'b00) begin
                    r_misalign_err <= 1'b1;
                end
            end else if (!stall) begin
                r_pc          <= r_pc + 64'd4;
                r_if_id_pc    <= r_pc;
                r_if_id_instr <= imem_instr;
                r_if_id_valid <= 1'b1;
            end
        end
    end

    assign pc_out       = r_pc;
    assign if_id_pc     = r_if_id_pc;
    assign if_id_instr  = r_if_id_instr;
    assign if_id_valid  = r_if_id_valid;
    assign flush        = w_redirect;
    assign misalign_err = r_misalign_err;
    assign taken_count  = r_taken_count;
    assign o_state_dbg  = r_state;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Table-driven bench for pc_fetch_stage: each record drives one cycle and carries
// the expected flush for that cycle plus the expected registered state after the edge.
module tb_pc_fetch_stage;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br_en;
        logic        ams;
        logic [63:0] target;
        logic [31:0] instr;
        logic        e_flush;
        logic [63:0] e_pc;
        logic [63:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_mis;
        logic [31:0] e_tc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_en;
    logic        addermuxselect;
    logic [63:0] branch_target;
    logic [31:0] imem_instr;
    logic [63:0] pc_out;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        flush;
    logic        misalign_err;
    logic [31:0] taken_count;
    logic        o_state_dbg;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec;
    int   n_miss;

    pc_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_en      (branch_en),
        .addermuxselect (addermuxselect),
        .branch_target  (branch_target),
        .imem_instr     (imem_instr),
        .pc_out         (pc_out),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .flush          (flush),
        .misalign_err   (misalign_err),
        .taken_count    (taken_count),
        .o_state_dbg    (o_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rst_n, input logic stl, input logic be, input logic am,
                       input logic [63:0] tgt, input logic [31:0] ins, input logic ef,
                       input logic [63:0] epc, input logic [63:0] eifpc, input logic [31:0] eins,
                       input logic ev, input logic em, input logic [31:0] etc_v);
        vec_t v;
        v.rst_n = rst_n; v.stall = stl; v.br_en = be; v.ams = am; v.target = tgt; v.instr = ins;
        v.e_flush = ef; v.e_pc = epc; v.e_ifpc = eifpc; v.e_instr = eins; v.e_valid = ev;
        v.e_mis = em; v.e_tc = etc_v;
        vecs.push_back(v);
    endtask

    task automatic chk64(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive on the falling edge, check flush combinationally, then check state after the rise.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset          = v.rst_n;
        stall          = v.stall;
        branch_en      = v.br_en;
        addermuxselect = v.ams;
        branch_target  = v.target;
        imem_instr     = v.instr;
        exp_q.push_back(v);
        #1;
        chk64("flush", idx, {63'd0, flush}, {63'd0, v.e_flush});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk64("pc_out", idx, pc_out, e.e_pc);
        chk64("if_id_pc", idx, if_id_pc, e.e_ifpc);
        chk64("if_id_instr", idx, {32'd0, if_id_instr}, {32'd0, e.e_instr});
        chk64("if_id_valid", idx, {63'd0, if_id_valid}, {63'd0, e.e_valid});
        chk64("misalign_err", idx, {63'd0, misalign_err}, {63'd0, e.e_mis});
        chk64("taken_count", idx, {32'd0, taken_count}, {32'd0, e.e_tc});
    endtask

    initial begin
        logic [31:0] ins;
        n_vec = 0;
        n_miss = 0;
        reset = 1'b0; stall = 1'b0; branch_en = 1'b0; addermuxselect = 1'b0;
        branch_target = 64'd0; imem_instr = 32'd0;

        // reset with a live branch request: flush must stay low
        add(0,0,1,1, 64'h100, 32'h13, 0, 64'h0, 64'h0, 32'h13, 0, 0, 0);
        // straight-line fetch from 0 up to 0x20
        for (int r = 1; r <= 8; r++) begin
            ins = (r == 1) ? 32'h13 : (r == 2) ? 32'h93 : (32'h0000_0013 | (32'(r) << 7));
            add(1,0,0,0, 64'h0, ins, 0, 64'(4*r), 64'(4*(r-1)), ins, 1, 0, 0);
        end
        // taken branch at 0x20 to 0x100
        add(1,0,1,1, 64'h100, 32'hDEAD_0013, 1, 64'h100, 64'h0, 32'h13, 0, 0, 1);
        // condition still true in the shadow cycle: ignored
        add(1,0,1,1, 64'h300, 32'hAAAA_0013, 0, 64'h104, 64'h100, 32'hAAAA_0013, 1, 0, 1);
        // comparator true without branch_en: no redirect
        add(1,0,0,1, 64'h400, 32'hBBBB_0013, 0, 64'h108, 64'h104, 32'hBBBB_0013, 1, 0, 1);
        // redirect under stall to a misaligned target
        add(1,1,1,1, 64'h202, 32'hCCCC_0013, 1, 64'h200, 64'h0, 32'h13, 0, 1, 2);
        // stall alone holds (shadow cycle, then run)
        add(1,1,0,0, 64'h0, 32'hDDDD_0013, 0, 64'h200, 64'h0, 32'h13, 0, 1, 2);
        add(1,1,0,0, 64'h0, 32'hDDDD_0013, 0, 64'h200, 64'h0, 32'h13, 0, 1, 2);
        add(1,0,0,0, 64'h0, 32'h0050_0093, 0, 64'h204, 64'h200, 32'h0050_0093, 1, 1, 2);
        add(1,1,0,0, 64'h0, 32'hEEEE_0013, 0, 64'h204, 64'h200, 32'h0050_0093, 1, 1, 2);
        // reset overrides a redirect in RUN
        add(0,0,1,1, 64'h500, 32'h0, 0, 64'h0, 64'h0, 32'h13, 0, 0, 0);
        // redirect to the top word, then wrap to 0
        add(1,0,1,1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h13, 0, 0, 1);
        add(1,0,0,0, 64'h0, 32'h33, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h33, 1, 0, 1);
        // redirect, then reset lands in the shadow cycle
        add(1,0,1,1, 64'h41, 32'h0, 1, 64'h40, 64'h0, 32'h13, 0, 1, 2);
        add(0,0,1,1, 64'h80, 32'h0, 0, 64'h0, 64'h0, 32'h13, 0, 0, 0);
        // first post-reset cycle is RUN: redirect accepted
        add(1,0,1,1, 64'h80, 32'h0, 1, 64'h80, 64'h0, 32'h13, 0, 0, 1);
        add(1,0,0,0, 64'h0, 32'h0000_0113, 0, 64'h84, 64'h80, 32'h0000_0113, 1, 0, 1);

        foreach (vecs[i]) apply(vecs[i], i);

        // saturation: preload the counter one below the ceiling
        @(negedge clk);
        branch_en = 1'b0; addermuxselect = 1'b0; stall = 1'b1;
        force dut.r_taken_count = 32'hFFFF_FFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.r_taken_count;
        begin
            vec_t s;
            s.rst_n = 1; s.stall = 1; s.br_en = 1; s.ams = 1; s.target = 64'h1000; s.instr = 32'h13;
            s.e_flush = 1; s.e_pc = 64'h1000; s.e_ifpc = 64'h0; s.e_instr = 32'h13; s.e_valid = 0;
            s.e_mis = 0; s.e_tc = 32'hFFFF_FFFF;
            apply(s, 100);
            s.br_en = 0; s.ams = 0; s.e_flush = 0; s.e_pc = 64'h1000;
            apply(s, 101);
            s.br_en = 1; s.ams = 1; s.target = 64'h2000; s.e_flush = 1; s.e_pc = 64'h2000;
            apply(s, 102);
        end

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL exp_q_drain: got %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
